// File: rtl/param_fifo_pkg.sv
// Shared types and defaults for the parameterised single-clock FIFO.
// The verification environment imports this package as well.
package param_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_AE_THRESH  = 1;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned fifo_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : param_fifo_pkg

// File: rtl/fifo_ptr_ctr.sv
// Modulo-DEPTH wrap counter used for the FIFO read and write pointers.
// DEPTH need not be a power of two; the pointer wraps from DEPTH-1 to 0.
module fifo_ptr_ctr #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (inc) begin
      if (r_ptr == PW'(DEPTH - 1)) r_ptr <= '0;
      else                         r_ptr <= r_ptr + PW'(1);
    end
  end

  assign ptr = r_ptr;

endmodule : fifo_ptr_ctr

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with arbitrary depth, STD or FWFT read mode, programmable
// almost-full/almost-empty thresholds, occupancy output and sticky error flags.
module param_sync_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter fifo_mode_e  MODE       = FIFO_STD,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 1,
  parameter int unsigned AE_THRESH  = DEF_AE_THRESH,
  localparam int unsigned CW        = fifo_cw(FIFO_DEPTH),
  localparam int unsigned PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
);

  // Reject illegal parameter combinations at elaboration.
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("param_sync_fifo: FIFO_DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_THRESH must be in 1..FIFO_DEPTH");
  end
  if (AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("param_sync_fifo: AE_THRESH must be in 0..FIFO_DEPTH-1");
  end

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]         r_count;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_ovf_sticky;
  logic                  r_udf_sticky;

  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_wr_rej;
  logic                  w_rd_rej;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_rd_ok  = rd_en & ~w_empty;
  // A write at full still fits when a pop frees the head slot in the same cycle.
  assign w_wr_ok  = wr_en & (~w_full | rd_en);
  assign w_wr_rej = wr_en & ~w_wr_ok;
  assign w_rd_rej = rd_en & w_empty;

  fifo_ptr_ctr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_wr_ok),
    .ptr (w_wr_ptr)
  );

  fifo_ptr_ctr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_rd_ok),
    .ptr (w_rd_ptr)
  );

  // Storage array: intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) r_mem[w_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_wr_ack     <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_udf_sticky <= 1'b0;
    end else begin
      r_count     <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
      r_wr_ack    <= w_wr_ok;
      r_overflow  <= w_wr_rej;
      r_underflow <= w_rd_rej;
      // A new error in the same cycle as err_clr keeps the flag set.
      if (w_wr_rej)     r_ovf_sticky <= 1'b1;
      else if (err_clr) r_ovf_sticky <= 1'b0;
      if (w_rd_rej)     r_udf_sticky <= 1'b1;
      else if (err_clr) r_udf_sticky <= 1'b0;
    end
  end

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign data_out = r_mem[w_rd_ptr];
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] r_data_out;
    always_ff @(posedge clk) begin
      if (rst)          r_data_out <= '0;
      else if (w_rd_ok) r_data_out <= r_mem[w_rd_ptr];
    end
    assign data_out = r_data_out;
  end

  assign count       = r_count;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count >= CW'(AF_THRESH));
  assign almostempty = (r_count <= CW'(AE_THRESH));
  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign ovf_sticky  = r_ovf_sticky;
  assign udf_sticky  = r_udf_sticky;

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: depth-5 STD and FWFT instances plus a
// depth-8 STD instance with custom thresholds, all on shared stimulus.
module tb_param_sync_fifo;
  import param_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, err_clr;
  logic [7:0] data_in;

  always #5 clk = ~clk;

  logic [7:0] s_dout, f_dout, t_dout;
  logic [2:0] s_cnt, f_cnt;
  logic [3:0] t_cnt;
  logic s_full, s_empty, s_af, s_ae, s_ack, s_ovf, s_udf, s_ovs, s_uds;
  logic f_full, f_empty, f_af, f_ae, f_ack, f_ovf, f_udf, f_ovs, f_uds;
  logic t_full, t_empty, t_af, t_ae, t_ack, t_ovf, t_udf, t_ovs, t_uds;

  param_sync_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .MODE(FIFO_STD)) u_std5 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(s_dout), .count(s_cnt), .full(s_full),
    .empty(s_empty), .almostfull(s_af), .almostempty(s_ae), .wr_ack(s_ack),
    .overflow(s_ovf), .underflow(s_udf), .ovf_sticky(s_ovs), .udf_sticky(s_uds));

  param_sync_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .MODE(FIFO_FWFT)) u_fwft5 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(f_dout), .count(f_cnt), .full(f_full),
    .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .wr_ack(f_ack),
    .overflow(f_ovf), .underflow(f_udf), .ovf_sticky(f_ovs), .udf_sticky(f_uds));

  param_sync_fifo #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .MODE(FIFO_STD),
                    .AF_THRESH(6), .AE_THRESH(2)) u_thr8 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(t_dout), .count(t_cnt), .full(t_full),
    .empty(t_empty), .almostfull(t_af), .almostempty(t_ae), .wr_ack(t_ack),
    .overflow(t_ovf), .underflow(t_udf), .ovf_sticky(t_ovs), .udf_sticky(t_uds));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample 1ns later.
  task automatic step(input logic w, input logic r, input logic [7:0] d,
                      input logic c, input logic rs);
    wr_en = w; rd_en = r; data_in = d; err_clr = c; rst = rs;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
  endtask

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    int         cnt;
    logic       ack;
    logic       ovf;
    logic       udf;
    logic       ovs;
    logic       uds;
    logic [7:0] dout;
    logic [7:0] fw;
  } vec_t;

  vec_t tbl [23];

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_in = '0;

    //          w  r  din    cnt ack ovf udf ovs uds dout   fwft head
    tbl[0]  = '{1, 0, 8'h11, 1,  1,  0,  0,  0,  0,  8'h00, 8'h11};
    tbl[1]  = '{1, 0, 8'h12, 2,  1,  0,  0,  0,  0,  8'h00, 8'h11};
    tbl[2]  = '{1, 0, 8'h13, 3,  1,  0,  0,  0,  0,  8'h00, 8'h11};
    tbl[3]  = '{1, 0, 8'h14, 4,  1,  0,  0,  0,  0,  8'h00, 8'h11};
    tbl[4]  = '{1, 0, 8'h15, 5,  1,  0,  0,  0,  0,  8'h00, 8'h11};
    tbl[5]  = '{1, 0, 8'h16, 5,  0,  1,  0,  1,  0,  8'h00, 8'h11};
    tbl[6]  = '{0, 1, 8'h00, 4,  0,  0,  0,  1,  0,  8'h11, 8'h12};
    tbl[7]  = '{0, 1, 8'h00, 3,  0,  0,  0,  1,  0,  8'h12, 8'h13};
    tbl[8]  = '{0, 1, 8'h00, 2,  0,  0,  0,  1,  0,  8'h13, 8'h14};
    tbl[9]  = '{0, 1, 8'h00, 1,  0,  0,  0,  1,  0,  8'h14, 8'h15};
    tbl[10] = '{0, 1, 8'h00, 0,  0,  0,  0,  1,  0,  8'h15, 8'h00};
    tbl[11] = '{0, 1, 8'h00, 0,  0,  0,  1,  1,  1,  8'h15, 8'h00};
    tbl[12] = '{1, 1, 8'h20, 1,  1,  0,  1,  1,  1,  8'h15, 8'h20};
    tbl[13] = '{1, 0, 8'h21, 2,  1,  0,  0,  1,  1,  8'h15, 8'h20};
    tbl[14] = '{1, 0, 8'h22, 3,  1,  0,  0,  1,  1,  8'h15, 8'h20};
    tbl[15] = '{1, 0, 8'h23, 4,  1,  0,  0,  1,  1,  8'h15, 8'h20};
    tbl[16] = '{1, 0, 8'h24, 5,  1,  0,  0,  1,  1,  8'h15, 8'h20};
    tbl[17] = '{1, 1, 8'hAA, 5,  1,  0,  0,  1,  1,  8'h20, 8'h21};
    tbl[18] = '{0, 1, 8'h00, 4,  0,  0,  0,  1,  1,  8'h21, 8'h22};
    tbl[19] = '{0, 1, 8'h00, 3,  0,  0,  0,  1,  1,  8'h22, 8'h23};
    tbl[20] = '{0, 1, 8'h00, 2,  0,  0,  0,  1,  1,  8'h23, 8'h24};
    tbl[21] = '{0, 1, 8'h00, 1,  0,  0,  0,  1,  1,  8'h24, 8'hAA};
    tbl[22] = '{0, 1, 8'h00, 0,  0,  0,  0,  1,  1,  8'hAA, 8'h00};

    // Reset state
    step(0, 0, 8'h00, 0, 1);
    chk("rst_count", 32'(s_cnt), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_full", 32'(s_full), 0);
    chk("rst_af", 32'(s_af), 0);
    chk("rst_ae", 32'(s_ae), 1);
    chk("rst_dout", 32'(s_dout), 0);
    chk("rst_pulses", 32'({s_ack, s_ovf, s_udf, s_ovs, s_uds}), 0);

    // Fill, overflow, drain, underflow and simultaneous cases on depth 5
    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].r, tbl[i].din, 0, 0);
      chk($sformatf("v%0d_count", i), 32'(s_cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_full", i), 32'(s_full), 32'(tbl[i].cnt == 5));
      chk($sformatf("v%0d_empty", i), 32'(s_empty), 32'(tbl[i].cnt == 0));
      chk($sformatf("v%0d_af", i), 32'(s_af), 32'(tbl[i].cnt >= 4));
      chk($sformatf("v%0d_ae", i), 32'(s_ae), 32'(tbl[i].cnt <= 1));
      chk($sformatf("v%0d_ack", i), 32'(s_ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d_ovf", i), 32'(s_ovf), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_udf", i), 32'(s_udf), 32'(tbl[i].udf));
      chk($sformatf("v%0d_ovs", i), 32'(s_ovs), 32'(tbl[i].ovs));
      chk($sformatf("v%0d_uds", i), 32'(s_uds), 32'(tbl[i].uds));
      chk($sformatf("v%0d_dout", i), 32'(s_dout), 32'(tbl[i].dout));
      chk($sformatf("v%0d_fw_empty", i), 32'(f_empty), 32'(tbl[i].cnt == 0));
      if (tbl[i].cnt != 0)
        chk($sformatf("v%0d_fw_dout", i), 32'(f_dout), 32'(tbl[i].fw));
    end

    // Pointer wrap: 12 write/read pairs through a depth-5 array
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'(i), 0, 0);
      chk($sformatf("wrap%0d_cnt_w", i), 32'(s_cnt), 1);
      chk($sformatf("wrap%0d_fw_dout", i), 32'(f_dout), 32'(i));
      step(0, 1, 8'h00, 0, 0);
      chk($sformatf("wrap%0d_dout", i), 32'(s_dout), 32'(i));
      chk($sformatf("wrap%0d_cnt_r", i), 32'(s_cnt), 0);
      chk($sformatf("wrap%0d_errs", i), 32'({s_ovf, s_udf, s_ovs, s_uds}), 0);
    end

    // FWFT head visible without a read
    step(0, 0, 8'h00, 0, 1);
    step(1, 0, 8'h3C, 0, 0);
    chk("fwft_dout", 32'(f_dout), 32'h3C);
    chk("fwft_empty0", 32'(f_empty), 0);
    step(0, 1, 8'h00, 0, 0);
    chk("fwft_empty1", 32'(f_empty), 1);

    // Thresholds on depth 8 (AF=6, AE=2)
    step(0, 0, 8'h00, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 8'(8'h40 + k), 0, 0);
      chk($sformatf("thr_fill%0d_cnt", k), 32'(t_cnt), 32'(k));
      chk($sformatf("thr_fill%0d_af", k), 32'(t_af), 32'(k >= 6));
      chk($sformatf("thr_fill%0d_ae", k), 32'(t_ae), 32'(k <= 2));
    end
    chk("thr_full", 32'(t_full), 1);
    chk("std5_ovs_after_fill", 32'(s_ovs), 1);
    for (int k = 7; k >= 0; k--) begin
      step(0, 1, 8'h00, 0, 0);
      chk($sformatf("thr_drain%0d_dout", k), 32'(t_dout), 32'(8'h40 + 8 - k));
      chk($sformatf("thr_drain%0d_af", k), 32'(t_af), 32'(k >= 6));
      chk($sformatf("thr_drain%0d_ae", k), 32'(t_ae), 32'(k <= 2));
    end
    step(0, 1, 8'h00, 0, 0);
    chk("thr_udf", 32'(t_udf), 1);
    chk("thr_uds", 32'(t_uds), 1);
    step(0, 1, 8'h00, 1, 0);
    chk("thr_clr_set_wins", 32'(t_uds), 1);
    chk("thr_clr_udf", 32'(t_udf), 1);
    step(0, 0, 8'h00, 1, 0);
    chk("thr_clr_uds", 32'(t_uds), 0);
    chk("std5_clr_ovs", 32'(s_ovs), 0);

    // Reset mid-operation, with a write request held during reset
    step(0, 0, 8'h00, 0, 1);
    step(0, 1, 8'h00, 0, 0);
    chk("mid_uds_set", 32'(s_uds), 1);
    for (int k = 0; k < 4; k++) step(1, 0, 8'(8'h31 + k), 0, 0);
    chk("mid_cnt4", 32'(s_cnt), 4);
    step(1, 0, 8'h99, 0, 1);
    chk("mid_rst_cnt", 32'(s_cnt), 0);
    chk("mid_rst_empty", 32'(s_empty), 1);
    chk("mid_rst_flags", 32'({s_ack, s_ovf, s_udf, s_ovs, s_uds}), 0);
    chk("mid_rst_dout", 32'(s_dout), 0);
    step(1, 0, 8'h55, 0, 0);
    chk("mid_wr_ack", 32'(s_ack), 1);
    chk("mid_wr_cnt", 32'(s_cnt), 1);
    step(0, 1, 8'h00, 0, 0);
    chk("mid_rd_dout", 32'(s_dout), 32'h55);
    chk("mid_rd_empty", 32'(s_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_param_sync_fifo

// File: doc/param_sync_fifo.md
# param_sync_fifo

Next-generation single-clock FIFO: generalised in width and depth, including non-power-of-two depths. Adds a selectable first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, a live occupancy output, and sticky error flags. It is a drop-in buffer between any two blocks in the same clock domain, and is verified with the existing FIFO UVM environment extended for the new features.

## Interface
- FIFO_WIDTH, 16: data width in bits, ≥1.
- FIFO_DEPTH, 8: number of entries, any integer ≥2.
- MODE, FIFO_STD: FIFO_STD (registered read data) or FIFO_FWFT (head entry visible without a read).
- AF_THRESH, FIFO_DEPTH-1: almostfull asserts when count ≥ AF_THRESH; legal range 1..FIFO_DEPTH.
- AE_THRESH, 1: almostempty asserts when count ≤ AE_THRESH; legal range 0..FIFO_DEPTH-1.
- Local CW = $clog2(FIFO_DEPTH+1).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- data_in  in  FIFO_WIDTH  write data.
- rd_en  in  1  read/pop request.
- err_clr  in  1  clears sticky error flags.
- data_out  out  FIFO_WIDTH  read data.
- count  out  CW  current occupancy, 0..FIFO_DEPTH.
- full, empty, almostfull, almostempty  out  1 each  level flags.
- wr_ack  out  1  registered pulse: the previous cycle's write was accepted.
- overflow, underflow  out  1 each  registered pulse: the previous cycle's write or read was rejected.
- ovf_sticky, udf_sticky  out  1 each  latched error flags.

## Operation
- rd_ok = rd_en & !empty.
- wr_ok = wr_en & (!full | rd_en): a write at full is accepted when a read occurs in the same cycle.
- Writes a rejected write at full → overflow; rd_en at empty → underflow. At empty with both enables set, the write is accepted and the read is rejected.
- count next value = count + wr_ok − rd_ok. At full with both enables, count is unchanged and both operations occur.
- wr_ptr and rd_ptr each range over 0..FIFO_DEPTH-1 and wrap from FIFO_DEPTH-1 to 0. Each advances on wr_ok or rd_ok respectively.
- FIFO_STD: on rd_ok, data_out ← mem[rd_ptr] at the clock edge; otherwise data_out holds its value.
- FIFO_FWFT: data_out = mem[rd_ptr] combinationally and is valid whenever !empty; rd_ok pops the entry.
- Level flags are combinational from count: full = (count==FIFO_DEPTH), empty = (count==0), almostfull = (count≥AF_THRESH), almostempty = (count≤AE_THRESH).
- Sticky flags: ovf_sticky sets on a rejected write and udf_sticky sets on a rejected read. Both clear on err_clr. If a set and err_clr occur in the same cycle, set wins.
- Memory contents are not reset and not readable while empty.

## Timing
- Reset (rst high at an edge) forces: wr_ptr=rd_ptr=0, count=0, data_out=0 (FIFO_STD), wr_ack=overflow=underflow=0, and ovf_sticky=udf_sticky=0.
- Resulting flag values after reset: empty=1, almostempty=1, full=0, almostfull=0.
- Reset has priority over all inputs in that cycle. Reset mid-stream discards all contents, and the next cycle starts from empty.
- Write → visible: count and empty update at the edge that accepts the write.
  - FIFO_FWFT: data_out is valid in the cycle after the write.
  - FIFO_STD: data becomes readable with rd_en in that same following cycle, and appears on data_out one cycle after the read is accepted.
- wr_ack, overflow and underflow are registered single-cycle pulses, asserted the cycle after the triggering edge. Continuous attempts produce continuous assertion.
- No combinational path exists from wr_en or rd_en to any output, except through the FWFT data_out mux, which depends on rd_ptr only.

## Structure
- Package param_fifo_pkg holds typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT} and the shared default constants. The UVM environment imports the same package.
- Sub-module fifo_ptr_ctr (parameter DEPTH; ports clk, rst, inc, ptr) implements the modulo-DEPTH wrap counter. It is instantiated twice, for wr_ptr and rd_ptr.
- Elaboration-time assertions reject illegal parameter combinations: FIFO_DEPTH<2, or AF_THRESH/AE_THRESH outside their legal ranges.

## Test plan
- FIFO_DEPTH=5, FIFO_STD: write 0x11..0x15 → full=1, count=5. A 6th write gives overflow=1 for one cycle, ovf_sticky=1, wr_ack=0. Reading 5 times returns 0x11..0x15 in order, then empty=1.
- Wrap: FIFO_DEPTH=5, 12 interleaved write/read pairs with data 0..11 → output order 0..11, no overflow or underflow pulses, and the pointers pass through index 4→0.
- Simultaneous: at full (count=5), assert wr_en+rd_en with data 0xAA → count stays 5, oldest entry is read, wr_ack=1. At empty, assert wr_en+rd_en → count=1, underflow=1, wr_ack=1.
- FWFT: write 0x3C into an empty FIFO → the next cycle shows data_out=0x3C and empty=0 with no rd_en. Asserting rd_en then gives empty=1.
- Thresholds: FIFO_DEPTH=8, AF_THRESH=6, AE_THRESH=2. Fill 0→8 and check almostfull rises at count=6 and almostempty falls at count=3. Assert err_clr together with a new underflow → udf_sticky stays 1.
- Reset mid-operation: with count=4, pulse rst → the next cycle shows count=0, empty=1, all pulses and sticky flags 0. A subsequent write/read returns the new data only.
